ysyx_22040088_idu_pipe: RTL
===========================

// Module: ysyx_22040088_idu_pipe
// PURPOSE
//  Pipelined decode stage for the RV64 core: takes one instruction per beat from the IFU over valid/ready
//  and reads operands from the external regfile. Decodes into ALU op and sources, holds the result in an
//  output register for the EXU, and resolves JAL/JALR redirects. A per-register scoreboard stalls RAW and
//  WAW hazards against in-flight writes; writeback retires scoreboard entries.
// PARAMETERS
//  XLEN      64  datapath / PC width
//  NREG      32  architectural registers (16 for RV-E); register index width RW = $clog2(NREG)
//  SB_W      2   pending-write counter width per register (max 2**SB_W-1 outstanding writes per reg)
//  ALU_OP_W  12  width of one-hot ALU op bus
// PORTS
//  clk           in   1         clock, all state on rising edge
//  rst           in   1         asynchronous reset, active-low
//  in_valid      in   1         IFU instruction valid
//  in_ready      out  1         decode can accept this cycle
//  in_pc         in   XLEN      PC of in_inst
//  in_inst       in   32        instruction word
//  rf_raddr1/2   out  RW        regfile read addresses (= inst[19:15], inst[24:20] truncated to RW)
//  rf_rdata1/2   in   XLEN      regfile read data, combinational, same cycle
//  wb_valid      in   1         writeback retiring a write
//  wb_rd         in   RW        writeback destination
//  wb_data       in   XLEN      writeback data (used only with IDU_WB_BYPASS_EN)
//  flush         in   1         discard held instruction (downstream trap/redirect)
//  out_valid     out  1         decoded instruction valid to EXU
//  out_ready     in   1         EXU accepts
//  out_pc        out  XLEN      PC of held instruction
//  out_alu_op    out  ALU_OP_W  one-hot ALU op; bit0 = ADD
//  out_src1/2    out  XLEN      ALU operands
//  out_rd        out  RW        destination
//  out_rf_we     out  1         instruction writes rd (forced 0 when rd==0)
//  out_illegal   out  1         unsupported opcode; alu_op = 0, rf_we = 0
//  redir_valid   out  1         one-cycle pulse: IFU must fetch from redir_pc
//  redir_pc      out  XLEN      jump target
// BEHAVIOUR
//  - Reset: out_valid, redir_valid, out_illegal, out_rf_we = 0; all data outputs = 0; all scoreboard counters = 0.
//  - Decode: LUI src1=0, src2=sext(immU<<12); AUIPC pc, sext(immU<<12); OP-IMM ADDI rs1, sext(immI);
//    OP ADD rs1, rs2; JAL/JALR pc, 4 (link). All others are illegal. ALU op = ADD for every legal instruction.
//  - Hazard: stall if a used rs (non-zero) has count!=0, or if rf_we and count[rd] is saturated.
//  - in_ready = !flush && !hazard && !redir_block && (!out_valid || out_ready). Fire = in_valid && in_ready.
//  - Fire loads the output regs the next edge, so latency is 1 cycle. out_valid stays held, stable, until
//    out_ready; it is never dropped without out_ready or flush.
//  - Scoreboard: count[rd]++ on fire with rf_we; count[wb_rd]-- on wb_valid with wb_rd!=0. When both hit the
//    same reg in one cycle, the count is unchanged. x0 is never tracked. Decrement at 0 is ignored
//    (a verification assertion must fire).
//  - Jumps: JAL target = pc+sext(immJ); JALR target = (rs1+sext(immI)) & ~1. redir_valid pulses in the
//    cycle out_valid rises for the jump. redir_block keeps in_ready=0 in that cycle, because the IFU beat
//    there is wrong-path.
//  - Flush (synchronous): the next edge clears out_valid and redir_valid. If the flushed instruction had
//    rf_we, roll back with count[out_rd]--, combined with any same-cycle wb on the same reg
//    (both on the same reg: net -2). No fire in a flush cycle.
//  - Reset mid-operation clears everything immediately, including a pending redirect.
// CONFIGURATION
//  IDU_WB_BYPASS_EN defined:
//   - A rs with count==1 and wb_valid && wb_rd==rs in the same cycle does not stall.
//   - The operand takes wb_data instead of rf_rdata; JALR target uses the bypassed value too.
//  IDU_WB_BYPASS_EN undefined:
//   - Such a rs stalls one extra cycle, until count reaches 0.
//   - wb_data is unused.
// TESTING
//  - Reset: drop rst mid-stream with out_valid=1 -> out_valid=0 and redir_valid=0 at once. After release,
//    in_ready=1 and every count is 0.
//  - addi x1,x0,5 then addi x2,x1,1 back-to-back -> the second stalls (in_ready=0) until wb_valid,wb_rd=1.
//    Fire on the next cycle with src1=rf_rdata1. With bypass: fire in the wb cycle, src1=wb_data.
//  - out_ready=0 for 3 cycles with an instruction held -> out_* stable, in_ready=0.
//    out_ready=1 -> next instruction accepted the same cycle.
//  - jal x1,+16 at pc 0x8000_0000 -> out_src1=0x8000_0000, src2=4, redir_valid pulse with
//    redir_pc=0x8000_0010; in_ready=0 in that cycle.
//  - jalr x0,3(x5) with x5=0x100 -> redir_pc=0x102, out_rf_we=0, count[0] stays 0.
//  - Flush with held addi x3 (count[3]=1) and wb_valid,wb_rd=3 -> count[3]=0 after net -2 clamps?
//    No: preset count[3]=2 -> 0. out_valid=0, no fire in the flush cycle.

Source files
------------

// File: rtl/ysyx_22040088_idu_pipe_if.sv
// IFU-side and EXU-side handshake bundle of the decode stage.
// slave = decode stage, master = IFU/EXU side driving it.
interface ysyx_22040088_idu_pipe_if #(
  parameter int XLEN     = 64,
  parameter int RW       = 5,
  parameter int ALU_OP_W = 12
);
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     in_pc;
  logic [31:0]         in_inst;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [ALU_OP_W-1:0] out_alu_op;
  logic [XLEN-1:0]     out_src1;
  logic [XLEN-1:0]     out_src2;
  logic [RW-1:0]       out_rd;
  logic                out_rf_we;
  logic                out_illegal;
  logic                redir_valid;
  logic [XLEN-1:0]     redir_pc;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_op,
    input  out_src1, out_src2, out_rd, out_rf_we,
    input  out_illegal, redir_valid, redir_pc
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_alu_op,
    output out_src1, out_src2, out_rd, out_rf_we,
    output out_illegal, redir_valid, redir_pc
  );
endinterface

// File: rtl/ysyx_22040088_idu_pipe.sv
// RV64 decode stage: operand fetch, scoreboard stalls, JAL/JALR redirect.
// Define IDU_WB_BYPASS_EN to forward same-cycle writeback data.
module ysyx_22040088_idu_pipe #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int SB_W     = 2,
  parameter int ALU_OP_W = 12,
  parameter int RW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  ysyx_22040088_idu_pipe_if.slave io,
  output logic [RW-1:0]   rf_raddr1,
  output logic [RW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_u, imm_j;

  assign inst = io.in_inst;
  assign pc   = io.in_pc;
  assign rs1  = inst[15 +: RW];
  assign rs2  = inst[20 +: RW];
  assign rd   = inst[7 +: RW];

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_addi, is_add, is_jal, is_jalr;
  logic legal, use1, use2, dec_we, is_jump;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    is_lui   = 1'b0;
    is_auipc = 1'b0;
    is_addi  = 1'b0;
    is_add   = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    unique case (1'b1)
      opc == 7'b0110111: is_lui   = 1'b1;
      opc == 7'b0010111: is_auipc = 1'b1;
      opc == 7'b0010011: is_addi  = f3 == 3'b000;
      opc == 7'b0110011: is_add   = f3 == 3'b000 && f7 == 7'b0;
      opc == 7'b1101111: is_jal   = 1'b1;
      opc == 7'b1100111: is_jalr  = f3 == 3'b000;
      default: ;
    endcase
  end

  assign legal   = is_lui | is_auipc | is_addi | is_add | is_jal | is_jalr;
  assign use1    = is_addi | is_add | is_jalr;
  assign use2    = is_add;
  assign dec_we  = legal && rd != '0;
  assign is_jump = is_jal | is_jalr;

  logic [NREG-1:0][SB_W-1:0] cnt, cnt_nxt;
  logic            ok1, ok2;
  logic [XLEN-1:0] v1, v2;

`ifdef IDU_WB_BYPASS_EN
  logic hit1, hit2;
  assign hit1 = wb_valid && wb_rd == rs1 && rs1 != '0;
  assign hit2 = wb_valid && wb_rd == rs2 && rs2 != '0;
  assign ok1  = hit1 && cnt[rs1] == SB_W'(1);
  assign ok2  = hit2 && cnt[rs2] == SB_W'(1);
  assign v1   = hit1 ? wb_data : rf_rdata1;
  assign v2   = hit2 ? wb_data : rf_rdata2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign ok1 = 1'b0;
  assign ok2 = 1'b0;
  assign v1  = rf_rdata1;
  assign v2  = rf_rdata2;
`endif

  logic haz, fire;

  assign haz = (use1 && rs1 != '0 && cnt[rs1] != '0 && !ok1)
            || (use2 && rs2 != '0 && cnt[rs2] != '0 && !ok2)
            || (dec_we && cnt[rd] == {SB_W{1'b1}});

  // a live redirect means this cycle's IFU beat is wrong-path
  assign io.in_ready = !flush && !haz && !io.redir_valid
                    && (!io.out_valid || io.out_ready);
  assign fire = io.in_valid && io.in_ready;

  logic [XLEN-1:0] src1, src2, tgt, jalr_sum;

  assign jalr_sum = v1 + imm_i;

  always_comb begin
    src1 = '0;
    src2 = '0;
    tgt  = '0;
    unique case (1'b1)
      is_lui: src2 = imm_u;
      is_auipc: begin
        src1 = pc;
        src2 = imm_u;
      end
      is_addi: begin
        src1 = v1;
        src2 = imm_i;
      end
      is_add: begin
        src1 = v1;
        src2 = v2;
      end
      is_jal: begin
        src1 = pc;
        src2 = XLEN'(4);
        tgt  = pc + imm_j;
      end
      is_jalr: begin
        src1 = pc;
        src2 = XLEN'(4);
        tgt  = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  logic underflow;

  // flush rollback and writeback both retire; clamp at zero
  always_comb begin
    cnt_nxt   = cnt;
    underflow = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      logic [SB_W:0] up;
      logic [1:0]    dn;
      up = {1'b0, cnt[r]}
         + (SB_W+1)'(fire && dec_we && rd == RW'(r));
      dn = 2'(wb_valid && wb_rd == RW'(r))
         + 2'(flush && io.out_valid && io.out_rf_we
              && io.out_rd == RW'(r));
      if (up >= (SB_W+1)'(dn)) begin
        cnt_nxt[r] = SB_W'(up - (SB_W+1)'(dn));
      end else begin
        cnt_nxt[r] = '0;
        underflow  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      io.out_valid   <= 1'b0;
      io.out_pc      <= '0;
      io.out_alu_op  <= '0;
      io.out_src1    <= '0;
      io.out_src2    <= '0;
      io.out_rd      <= '0;
      io.out_rf_we   <= 1'b0;
      io.out_illegal <= 1'b0;
      io.redir_valid <= 1'b0;
      io.redir_pc    <= '0;
    end else begin
      cnt            <= cnt_nxt;
      io.redir_valid <= 1'b0;
      if (flush) begin
        io.out_valid <= 1'b0;
      end else if (fire) begin
        io.out_valid   <= 1'b1;
        io.out_pc      <= pc;
        io.out_alu_op  <= legal ? ALU_OP_W'(1) : '0;
        io.out_src1    <= src1;
        io.out_src2    <= src2;
        io.out_rd      <= rd;
        io.out_rf_we   <= dec_we;
        io.out_illegal <= !legal;
        io.redir_valid <= is_jump;
        if (is_jump) io.redir_pc <= tgt;
      end else if (io.out_ready) begin
        io.out_valid <= 1'b0;
      end
    end
  end

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst) !underflow
  );

endmodule
